// File: rtl/gb_irq_pkg.sv
// Shared types and constants for the Game Boy interrupt controller.
package gb_irq_pkg;

  localparam int unsigned NUM_IRQ_DEF = 5;

  typedef enum logic [2:0] {
    IRQ_VBLANK = 3'd0,
    IRQ_STAT   = 3'd1,
    IRQ_TIMER  = 3'd2,
    IRQ_SERIAL = 3'd3,
    IRQ_JOYPAD = 3'd4
  } irq_id_e;

  localparam logic [15:0] IF_ADDR      = 16'hFF0F;
  localparam logic [15:0] IE_ADDR      = 16'hFFFF;
  localparam logic [7:0]  IF_READ_MASK = 8'hE0;

  typedef logic [4:0] irq_vec_t;

endpackage

// File: rtl/gb_irq_prio_enc.sv
// Lowest-index-wins one-hot priority encoder with a valid flag.
module gb_irq_prio_enc #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] grant,
  output logic         valid
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + W'(1));
  assign valid = |req;

endmodule

// File: rtl/gb_irq_ctrl.sv
// IF/IE register owner and CPU-side responder for interrupt requests and acknowledges.
// Optional GB_IRQ_EDGE_DETECT_EN: capture requests on rising edges instead of levels.
module gb_irq_ctrl #(
  parameter int unsigned NUM_IRQ = gb_irq_pkg::NUM_IRQ_DEF,
  parameter logic [15:0] IF_ADDR = gb_irq_pkg::IF_ADDR,
  parameter logic [15:0] IE_ADDR = gb_irq_pkg::IE_ADDR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        addr_i,
  input  logic [7:0]         data_i,
  input  logic               drive_data_bus,
  input  logic               clear_interrupt_flag,
  input  logic [NUM_IRQ-1:0] irq_req_i,
  output logic [7:0]         data_o,
  output logic               sel_o,
  output logic [7:0]         reg_IF,
  output logic [7:0]         reg_IE,
  output logic               irq_pending_o,
  output logic [NUM_IRQ-1:0] ack_vec_o
);

  import gb_irq_pkg::*;

  logic [NUM_IRQ-1:0] if_q;
  logic [NUM_IRQ-1:0] if_nxt;
  logic [7:0]         ie_q;
  logic [NUM_IRQ-1:0] ack_vec_q;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] ack_onehot;
  logic               ack_valid;
  logic [NUM_IRQ-1:0] req_cap;
  logic               hit_if;
  logic               hit_ie;
  logic               wr_if;
  logic               wr_ie;

  assign hit_if = (addr_i == IF_ADDR);
  assign hit_ie = (addr_i == IE_ADDR);
  assign wr_if  = drive_data_bus && hit_if;
  assign wr_ie  = drive_data_bus && hit_ie;

  // IE bits above the request count are storage only.
  assign pend = if_q & ie_q[NUM_IRQ-1:0];

  gb_irq_prio_enc #(.W(NUM_IRQ)) u_prio_enc (
    .req   (pend),
    .grant (ack_onehot),
    .valid (ack_valid)
  );

`ifdef GB_IRQ_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] req_hist_q;

  assign req_cap = irq_req_i & ~req_hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_hist_q <= '0;
    end else begin
      req_hist_q <= irq_req_i;
    end
  end
`else
  assign req_cap = irq_req_i;
`endif

  // Write first, then clear the ack target (chosen from pre-write IF), then OR in requests.
  always_comb begin
    if_nxt = if_q;
    if (wr_if) begin
      if_nxt = data_i[NUM_IRQ-1:0];
    end
    if (clear_interrupt_flag) begin
      if_nxt = if_nxt & ~ack_onehot;
    end
    if_nxt = if_nxt | req_cap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_q      <= '0;
      ie_q      <= 8'h00;
      ack_vec_q <= '0;
    end else begin
      if_q <= if_nxt;
      if (wr_ie) begin
        ie_q <= data_i;
      end
      if (clear_interrupt_flag) begin
        ack_vec_q <= ack_valid ? ack_onehot : '0;
      end
    end
  end

  // Zero-latency read mux; unused IF bits read back as ones.
  always_comb begin
    data_o = 8'h00;
    sel_o  = 1'b0;
    if (hit_if) begin
      sel_o  = 1'b1;
      data_o = IF_READ_MASK | 8'(if_q);
    end else if (hit_ie) begin
      sel_o  = 1'b1;
      data_o = ie_q;
    end
  end

  assign reg_IF        = 8'(if_q);
  assign reg_IE        = ie_q;
  assign irq_pending_o = |pend;
  assign ack_vec_o     = ack_vec_q;

endmodule
